// File: rtl/gray_to_bin_pipe.sv
// Pipelined Gray-to-binary decoder with valid/ready on both sides and bubble-collapsing stages.
// Optional input step checker enabled by defining GRAY_TO_BIN_PIPE_STEP_CHECK_EN.
module gray_to_bin_pipe #(
  parameter int unsigned DataWidth = 11,
  parameter int unsigned NumStages = 2
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  input  logic [DataWidth-1:0] data_in_i,
  input  logic                 data_in_valid_i,
  output logic                 data_in_ready_o,
  output logic [DataWidth-1:0] data_out_o,
  output logic                 data_out_valid_o,
  input  logic                 data_out_ready_i,
  output logic                 step_err_o
);

  localparam int unsigned Chunk = (DataWidth + NumStages - 1) / NumStages;

  // Bits owned by a stage, MSB-first in Chunk-sized slices; the last stage takes whatever is left.
  function automatic logic [DataWidth-1:0] stage_mask(input int unsigned stage);
    logic [DataWidth-1:0] m;
    int unsigned          owner;
    m = '0;
    for (int unsigned b = 0; b < DataWidth; b++) begin
      owner = (DataWidth - 1 - b) / Chunk;
      if (owner > NumStages - 1) owner = NumStages - 1;
      m[b] = (owner == stage);
    end
    return m;
  endfunction

  function automatic logic [DataWidth-1:0] resolve(input logic [DataWidth-1:0] word,
                                                   input logic [DataWidth-1:0] mask);
    logic [DataWidth-1:0] res;
    res = word;
    for (int unsigned j = 1; j < DataWidth; j++) begin
      if (mask[DataWidth-1-j]) res[DataWidth-1-j] = res[DataWidth-j] ^ res[DataWidth-1-j];
    end
    return res;
  endfunction

  // Each stage word holds resolved binary bits above its boundary and raw Gray bits below.
  logic [DataWidth-1:0] r_data [NumStages];
  logic [NumStages-1:0] r_valid;
  logic [DataWidth-1:0] w_src  [NumStages];
  logic [DataWidth-1:0] w_res  [NumStages];
  logic [NumStages-1:0] w_src_valid;
  logic [NumStages-1:0] w_load;

  assign w_src[0] = data_in_i;

  for (genvar s = 1; s < NumStages; s++) begin : g_link
    assign w_src[s] = r_data[s-1];
  end

  if (NumStages == 1) begin : g_valid_one
    assign w_src_valid = data_in_valid_i;
  end else begin : g_valid_multi
    assign w_src_valid = {r_valid[NumStages-2:0], data_in_valid_i};
  end

  always_comb begin
    for (int unsigned s = 0; s < NumStages; s++) begin
      w_res[s] = resolve(w_src[s], stage_mask(s));
    end
  end

  // Ready ripples upstream: a stage may load if it is empty or its successor loads.
  always_comb begin
    w_load = '0;
    w_load[NumStages-1] = ~r_valid[NumStages-1] | data_out_ready_i;
    for (int unsigned j = 1; j < NumStages; j++) begin
      w_load[NumStages-1-j] = ~r_valid[NumStages-1-j] | w_load[NumStages-j];
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_valid <= '0;
      for (int unsigned s = 0; s < NumStages; s++) begin
        r_data[s] <= '0;
      end
    end else begin
      for (int unsigned s = 0; s < NumStages; s++) begin
        if (w_load[s]) begin
          r_valid[s] <= w_src_valid[s];
          // Data only moves with a valid word so the output holds its last value during bubbles.
          if (w_src_valid[s]) r_data[s] <= w_res[s];
        end
      end
    end
  end

  assign data_in_ready_o  = w_load[0];
  assign data_out_o       = r_data[NumStages-1];
  assign data_out_valid_o = r_valid[NumStages-1];

`ifdef GRAY_TO_BIN_PIPE_STEP_CHECK_EN
  logic [DataWidth-1:0] r_prev;
  logic                 r_first;
  logic [NumStages-1:0] r_err;
  logic [NumStages-1:0] w_src_err;
  logic [DataWidth-1:0] w_diff;
  logic                 w_in_err;

  assign w_diff = data_in_i ^ r_prev;
  // Exactly one differing bit iff the difference is nonzero and a power of two.
  assign w_in_err = ~r_first &
                    ~((w_diff != '0) && ((w_diff & (w_diff - DataWidth'(1))) == '0));

  if (NumStages == 1) begin : g_err_one
    assign w_src_err = w_in_err;
  end else begin : g_err_multi
    assign w_src_err = {r_err[NumStages-2:0], w_in_err};
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_prev  <= '0;
      r_first <= 1'b1;
      r_err   <= '0;
    end else begin
      if (data_in_valid_i && w_load[0]) begin
        r_prev  <= data_in_i;
        r_first <= 1'b0;
      end
      for (int unsigned s = 0; s < NumStages; s++) begin
        if (w_load[s] && w_src_valid[s]) r_err[s] <= w_src_err[s];
      end
    end
  end

  assign step_err_o = r_err[NumStages-1];
`else
  assign step_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_gray_to_bin_pipe.sv
// Self-checking bench for gray_to_bin_pipe: directed steps plus randomized traffic
// against a queue-based reference model of decode, ordering and step flags.
module tb_gray_to_bin_pipe;

  localparam int DW = 11;
  localparam int NS = 3;

  logic          clk;
  logic          srst;
  logic [DW-1:0] din;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dout;
  logic          out_valid;
  logic          out_ready;
  logic          step_err;

  gray_to_bin_pipe #(.DataWidth(DW), .NumStages(NS)) u_dut (
    .clk_i            (clk),
    .srst_i           (srst),
    .data_in_i        (din),
    .data_in_valid_i  (in_valid),
    .data_in_ready_o  (in_ready),
    .data_out_o       (dout),
    .data_out_valid_o (out_valid),
    .data_out_ready_i (out_ready),
    .step_err_o       (step_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] q_data [$];
  logic          q_err  [$];
  logic          cap_err [$];
  logic [DW-1:0] cap_data [$];
  logic [DW-1:0] m_prev;
  logic          m_first;
  logic [DW-1:0] last_data;
  logic          last_err;
  logic          prev_hold;
  logic [DW-1:0] prev_od;
  logic          prev_oe;
  logic          last_out_fire;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] g2b(input logic [DW-1:0] g);
    logic [DW-1:0] b;
    b = '0;
    for (int k = 0; k < DW; k++) b = b ^ (g >> k);
    return b;
  endfunction

  function automatic logic [DW-1:0] b2g(input int unsigned v);
    logic [DW-1:0] b;
    b = DW'(v);
    return b ^ (b >> 1);
  endfunction

  // One clock: sample and score at negedge, let the edge happen, return at posedge+1.
  task automatic tick();
    logic          fin, fout, exp_rdy, ee;
    logic [DW-1:0] od, ed;
    logic          oe;
    @(negedge clk);
    od   = dout;
    oe   = step_err;
    fin  = in_valid && in_ready && !srst;
    fout = out_valid && out_ready && !srst;
    if (!srst) begin
      exp_rdy = out_ready || (q_data.size() < NS);
      check("in_ready", in_ready, exp_rdy);
    end
    if (prev_hold) begin
      check("hold_data", od, prev_od);
      check("hold_err", oe, prev_oe);
    end
    if (!out_valid) begin
      check("idle_data", od, last_data);
      check("idle_err", oe, last_err);
    end
    if (fout) begin
      if (q_data.size() == 0) begin
        check("spurious_out", q_data.size(), 1);
      end else begin
        ed = q_data.pop_front();
        ee = q_err.pop_front();
        check("out_data", od, ed);
        check("out_err", oe, ee);
      end
      cap_data.push_back(od);
      cap_err.push_back(oe);
      last_data = od;
      last_err  = oe;
    end
    last_out_fire = fout;
    if (fin) begin
      q_data.push_back(g2b(din));
`ifdef GRAY_TO_BIN_PIPE_STEP_CHECK_EN
      q_err.push_back(!m_first && ($countones(din ^ m_prev) != 1));
`else
      q_err.push_back(1'b0);
`endif
      m_prev  = din;
      m_first = 1'b0;
    end
    prev_hold = out_valid && !out_ready && !srst;
    prev_od   = od;
    prev_oe   = oe;
    if (srst) begin
      q_data.delete();
      q_err.delete();
      m_first   = 1'b1;
      last_data = '0;
      last_err  = 1'b0;
      prev_hold = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4 * NS + 4 && q_data.size() != 0; i++) tick();
    check("drain_empty", q_data.size(), 0);
    tick();
  endtask

  task automatic directed(input logic [DW-1:0] g, input logic [DW-1:0] exp_b, input string tag);
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    din       = g;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, lat, NS - 1);
    check(tag, dout, exp_b);
    tick();
  endtask

  initial begin
    int          gaps, fires, cnt;
    logic [DW-1:0] held;

    srst = 1'b1; din = '0; in_valid = 1'b0; out_ready = 1'b1;
    m_prev = '0; m_first = 1'b1; last_data = '0; last_err = 1'b0;
    prev_hold = 1'b0; prev_od = '0; prev_oe = 1'b0; last_out_fire = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", dout, 0);
    check("rst_err", step_err, 0);
    check("rst_ready", in_ready, 1);
    srst = 1'b0;

    directed(11'h003, 11'h002, "dir_003");
    directed(11'h400, 11'h7FF, "dir_400");
    directed(11'h000, 11'h000, "dir_000");
    drain();

    // Every Gray code at full rate: outputs NS..NS+2047 ticks after start, no gaps.
    gaps = 0; fires = 0;
    for (int t = 1; t <= 2048 + NS; t++) begin
      if (t <= 2048) begin
        in_valid = 1'b1;
        din      = b2g(t - 1);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (last_out_fire !== (t > NS)) gaps++;
      if (last_out_fire) fires++;
    end
    check("exh_gaps", gaps, 0);
    check("exh_count", fires, 2048);
    drain();

    // Backpressure: output stalled 5 cycles under continuous input.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    cnt       = 100;
    for (int t = 0; t < 5; t++) begin
      din = b2g(cnt);
      if (in_ready) cnt++;
      tick();
      if (t == 2) begin
        check("bp_ready_low", in_ready, 0);
        held = dout;
      end
    end
    check("bp_held", dout, held);
    check("bp_full", q_data.size(), NS);
    out_ready = 1'b1;
    fires = 0;
    for (int t = 0; t < 6; t++) begin
      din = b2g(cnt);
      if (in_ready) cnt++;
      tick();
      if (last_out_fire) fires++;
    end
    check("bp_resume", fires, 6);
    drain();

    // Random bubbles on both sides.
    for (int t = 0; t < 10000; t++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) din = din ^ (DW'(1) << $urandom_range(0, DW - 1));
      else din = DW'($urandom);
      tick();
    end
    drain();

    // Reset with two words in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    din = 11'h155; tick();
    din = 11'h0F0; tick();
    check("mid_inflight", q_data.size(), 2);
    srst = 1'b1;
    din  = 11'h333;
    tick();
    srst = 1'b0;
    in_valid = 1'b0;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", dout, 0);
    directed(11'h1A5, g2b(11'h1A5), "mid_next");
    drain();

    // Step checker sequence right after a reset.
    srst = 1'b1; tick(); srst = 1'b0;
    cap_err.delete();
    cap_data.delete();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    din = 11'h000; tick();
    din = 11'h001; tick();
    din = 11'h003; tick();
    din = 11'h003; tick();
    din = 11'h000; tick();
    drain();
    check("step_count", cap_err.size(), 5);
    if (cap_err.size() == 5) begin
      check("step_d3", cap_data[3], 11'h002);
      check("step_e0", cap_err[0], 0);
      check("step_e1", cap_err[1], 0);
      check("step_e2", cap_err[2], 0);
`ifdef GRAY_TO_BIN_PIPE_STEP_CHECK_EN
      check("step_e3", cap_err[3], 1);
      check("step_e4", cap_err[4], 1);
`else
      check("step_e3", cap_err[3], 0);
      check("step_e4", cap_err[4], 0);
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
